// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Single-cycle ops (AND, XOR, SLL, ADD, SUB, ADDI, SRAI)
// produce a registered result one edge after issue. MUL is a fixed-latency
// radix-2 shift-add that holds busy_o high while it iterates, so the hazard
// unit can stall the pipeline.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             zero_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_XOR  = 3'b001,
    OP_SLL  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_MUL  = 3'b101,
    OP_ADDI = 3'b110,
    OP_SRAI = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] shamt;

  assign shamt    = data2_i[SHAMT_W-1:0];
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle result; only the low shift-amount bits of B are used for shifts.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_ADDI: alu_res = data1_i + data2_i;
      OP_SRAI: alu_res = WIDTH'($signed(data1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: flush wins, then issue in IDLE, then one MUL iteration per edge.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    zero_d   = zero_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              state_d  = ST_MUL;
              acc_d    = '0;
              mcand_d  = data1_i;
              mplier_d = data2_i;
              cnt_d    = '0;
            end else begin
              data_d  = alu_res;
              zero_d  = (alu_res == '0);
              valid_d = 1'b1;
            end
          end
        end
        ST_MUL: begin
          // No early exit: latency is always WIDTH edges after issue.
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHAMT_W'(1);
          if (cnt_q == CNT_LAST) begin
            data_d  = acc_next;
            zero_d  = (acc_next == '0);
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign zero_o  = zero_q;
  assign busy_o  = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        zero_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .zero_o    (zero_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    valid_i   = 1'b1;
  endtask

  // Issues one MUL and follows it to completion. With add_during set, an
  // ADD 10+20 is held on the inputs with valid_i=1 for the whole MUL and
  // must only be taken in the cycle the MUL result appears.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic zexp, input bit add_during);
    int cyc;
    int busy_cnt;
    @(negedge clk_i);
    drive(OP_MUL, a, b);
    step();
    check({tag, "_valid_at_issue"}, 32'(valid_o), 32'd0);
    cyc      = 0;
    busy_cnt = busy_o ? 1 : 0;
    @(negedge clk_i);
    if (add_during) drive(OP_ADD, 32'd10, 32'd20);
    else            valid_i = 1'b0;
    while (cyc < 40 && !valid_o) begin
      step();
      cyc++;
      if (busy_o) busy_cnt++;
    end
    check({tag, "_latency"},   32'(cyc), 32'd32);
    check({tag, "_busy_cyc"},  32'(busy_cnt), 32'd32);
    check({tag, "_data"},      data_o, exp);
    check({tag, "_zero"},      32'(zero_o), 32'(zexp));
    check({tag, "_busy_done"}, 32'(busy_o), 32'd0);
    if (add_during) begin
      step();
      check({tag, "_add_valid"}, 32'(valid_o), 32'd1);
      check({tag, "_add_data"},  data_o, 32'd30);
      @(negedge clk_i);
      valid_i = 1'b0;
      step();
      check({tag, "_add_vclr"}, 32'(valid_o), 32'd0);
    end else begin
      step();
      check({tag, "_vclr"}, 32'(valid_o), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    int busy_seen;

    vecs[0] = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1] = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{OP_XOR,  32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0};
    vecs[3] = '{OP_AND,  32'h12345678, 32'h00000000, 32'h00000000, 1'b1};
    vecs[4] = '{OP_SLL,  32'h00000001, 32'h00000025, 32'h00000020, 1'b0};
    vecs[5] = '{OP_SRAI, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    vecs[6] = '{OP_SRAI, 32'h40000000, 32'h00000004, 32'h04000000, 1'b0};
    vecs[7] = '{OP_ADDI, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};

    rst_i     = 1'b0;
    flush_i   = 1'b0;
    valid_i   = 1'b0;
    ALUCtrl_i = OP_AND;
    data1_i   = '0;
    data2_i   = '0;

    // Reset state
    step();
    step();
    check("rst_data",  data_o, 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_zero",  32'(zero_o), 32'd1);
    check("rst_busy",  32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    check("idle_valid", 32'(valid_o), 32'd0);

    // Single-cycle ops, issued back to back: one result per edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("op%0d_data", i),  data_o, vecs[i].r);
      check($sformatf("op%0d_valid", i), 32'(valid_o), 32'd1);
      check($sformatf("op%0d_zero", i),  32'(zero_o), 32'(vecs[i].z));
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    step();
    check("op_vclr", 32'(valid_o), 32'd0);
    check("op_hold", data_o, 32'h00000000);

    // Multiplies
    run_mul("mul7x6",  32'd7,        32'd6,       32'd42,        1'b0, 1'b1);
    run_mul("mulneg",  32'hFFFFFFFD, 32'd5,       32'hFFFFFFF1,  1'b0, 1'b0);
    run_mul("mulwrap", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0);

    // Flush in the middle of a MUL
    @(negedge clk_i);
    drive(OP_ADD, 32'd100, 32'd23);
    step();
    check("pre_flush_data", data_o, 32'd123);
    @(negedge clk_i);
    drive(OP_MUL, 32'd7, 32'd6);
    step();
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) step();
    check("flush_busy_before", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b1;
    step();
    check("flush_busy",  32'(busy_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_data",  data_o, 32'd123);
    check("flush_zero",  32'(zero_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    pulses  = 0;
    repeat (40) begin
      step();
      if (valid_o) pulses++;
    end
    check("flush_no_pulse", 32'(pulses), 32'd0);

    // Flush beats an issue in IDLE
    @(negedge clk_i);
    flush_i = 1'b1;
    drive(OP_ADD, 32'd1, 32'd1);
    step();
    check("flush_issue_valid", 32'(valid_o), 32'd0);
    check("flush_issue_data",  data_o, 32'd123);
    @(negedge clk_i);
    flush_i = 1'b0;
    drive(OP_ADD, 32'd2, 32'd3);
    step();
    check("post_flush_data",  data_o, 32'd5);
    check("post_flush_valid", 32'(valid_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;

    // Asynchronous reset in the middle of a MUL
    @(negedge clk_i);
    drive(OP_MUL, 32'd3, 32'd3);
    step();
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) step();
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_data",  data_o, 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_zero",  32'(zero_o), 32'd1);
    check("arst_busy",  32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i     = 1'b1;
    pulses    = 0;
    busy_seen = 0;
    repeat (40) begin
      step();
      if (valid_o) pulses++;
      if (busy_o) busy_seen++;
    end
    check("arst_no_pulse", 32'(pulses), 32'd0);
    check("arst_no_busy",  32'(busy_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
